// File: rtl/fir_block_scheduler.sv
// Block scheduler for the 3-parallel FIR core: groups serial samples into 3-lane blocks,
// credit-gates issue against output FIFO space, and re-serialises the core results.
module fir_block_scheduler #(
  parameter int DATA_W      = 16,
  parameter int OUT_W       = 64,
  parameter int OFIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              flush,
  output logic              blk_valid,
  output logic [DATA_W-1:0] blk_x0,
  output logic [DATA_W-1:0] blk_x1,
  output logic [DATA_W-1:0] blk_x2,
  input  logic              core_valid,
  input  logic [OUT_W-1:0]  core_y0,
  input  logic [OUT_W-1:0]  core_y1,
  input  logic [OUT_W-1:0]  core_y2,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              busy,
  output logic              ovf_err
);

  localparam int AW = $clog2(OFIFO_DEPTH);
  localparam int CW = $clog2(OFIFO_DEPTH + 1);

  logic [1:0]         idx_r;
  logic [DATA_W-1:0]  lane0_r;
  logic [DATA_W-1:0]  lane1_r;
  logic [CW-1:0]      credits_r;
  logic [AW:0]        wptr_r;
  logic [AW:0]        rptr_r;
  logic [1:0]         phase_r;
  logic [3*OUT_W-1:0] mem_r [OFIFO_DEPTH];
  logic [3*OUT_W-1:0] head_s;

  logic accept_s, issue_s, full_s, empty_s, wr_s, pop_s;

  // Only the group-completing sample needs a credit; flush blocks acceptance that cycle.
  assign s_ready  = !flush && ((idx_r != 2'd2) || (credits_r != {CW{1'b0}}));
  assign accept_s = s_valid && s_ready;
  assign issue_s  = accept_s && (idx_r == 2'd2);
  assign empty_s  = (wptr_r == rptr_r);
  assign full_s   = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign wr_s     = core_valid && !full_s;
  assign m_valid  = !empty_s;
  assign pop_s    = m_valid && m_ready && (phase_r == 2'd2);
  assign busy     = (idx_r != 2'd0) || (credits_r != CW'(OFIFO_DEPTH));

  // Sample assembler: collect lanes 0 and 1, lane 2 goes straight to the block register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= 2'd0;
      lane0_r <= {DATA_W{1'b0}};
      lane1_r <= {DATA_W{1'b0}};
    end else if (flush) begin
      idx_r <= 2'd0;
    end else if (accept_s) begin
      case (idx_r)
        2'd0:    begin lane0_r <= s_data; idx_r <= 2'd1; end
        2'd1:    begin lane1_r <= s_data; idx_r <= 2'd2; end
        default: idx_r <= 2'd0;
      endcase
    end
  end

  // Block issue register: one-cycle pulse, lanes hold until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_valid <= 1'b0;
      blk_x0    <= {DATA_W{1'b0}};
      blk_x1    <= {DATA_W{1'b0}};
      blk_x2    <= {DATA_W{1'b0}};
    end else begin
      blk_valid <= issue_s;
      if (issue_s) begin
        blk_x0 <= lane0_r;
        blk_x1 <= lane1_r;
        blk_x2 <= s_data;
      end
    end
  end

  // Credit counter: issue takes a slot, completing an entry's last word returns one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_r <= CW'(OFIFO_DEPTH);
    end else begin
      case ({issue_s, pop_s})
        2'b10: credits_r <= credits_r - CW'(1);
        2'b01: begin
          if (credits_r != CW'(OFIFO_DEPTH)) credits_r <= credits_r + CW'(1);
        end
        default: credits_r <= credits_r;
      endcase
    end
  end

  // FIFO pointers, serialiser phase and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {(AW+1){1'b0}};
      rptr_r  <= {(AW+1){1'b0}};
      phase_r <= 2'd0;
      ovf_err <= 1'b0;
    end else begin
      if (wr_s) wptr_r <= wptr_r + (AW+1)'(1);
      if (pop_s) rptr_r <= rptr_r + (AW+1)'(1);
      if (core_valid && full_s) ovf_err <= 1'b1;
      if (m_valid && m_ready) begin
        case (phase_r)
          2'd0:    phase_r <= 2'd1;
          2'd1:    phase_r <= 2'd2;
          default: phase_r <= 2'd0;
        endcase
      end
    end
  end

  // Result storage; a full FIFO drops the write.
  always_ff @(posedge clk) begin
    if (wr_s) mem_r[wptr_r[AW-1:0]] <= {core_y2, core_y1, core_y0};
  end

  // Output word select; driven to zero while the FIFO is empty.
  always_comb begin
    head_s = mem_r[rptr_r[AW-1:0]];
    m_data = {OUT_W{1'b0}};
    if (empty_s) begin
      m_data = {OUT_W{1'b0}};
    end else begin
      case (phase_r)
        2'd0:    m_data = head_s[OUT_W-1:0];
        2'd1:    m_data = head_s[2*OUT_W-1:OUT_W];
        default: m_data = head_s[3*OUT_W-1:2*OUT_W];
      endcase
    end
  end

endmodule
